// File: rtl/tone_sample_streamer_pkg.sv
// Shared types and widths for the tone sample streamer.
package tone_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } tone_state_e;

  localparam int SAMPLE_W          = 32;
  localparam int HALF_PERIOD_W     = 32;
  localparam int DURATION_W        = 24;
  localparam int DEFAULT_AMPLITUDE = 100000000;

endpackage

// File: rtl/tone_sample_streamer_tick_gen.sv
// Free-running sample-rate divider; o_tick pulses for one cycle on each wrap.
module sample_tick_gen
  import tone_stream_pkg::*;
#(
  parameter int SAMPLE_DIV = 1042
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tone_sample_streamer.sv
// Enveloped square-wave note player feeding the audio-out FIFO, one sample per tick.
// Optional overrun counter output enabled by defining TONE_STREAMER_OVERRUN_CNT_EN.
module tone_sample_streamer
  import tone_stream_pkg::*;
#(
  parameter int SAMPLE_DIV   = 1042,
  parameter int AMPLITUDE    = DEFAULT_AMPLITUDE,
  parameter int ATTACK_STEP  = 2000000,
  parameter int RELEASE_STEP = 2000000
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic                        note_valid,
  output logic                        note_ready,
  input  logic [HALF_PERIOD_W-1:0]    note_half_period,
  input  logic [DURATION_W-1:0]       note_duration,
  input  logic                        mute,
  input  logic                        audio_out_allowed,
  output logic                        write_audio_out,
  output logic signed [SAMPLE_W-1:0]  left_channel_audio_out,
  output logic signed [SAMPLE_W-1:0]  right_channel_audio_out,
  output logic                        busy
`ifdef TONE_STREAMER_OVERRUN_CNT_EN
  ,
  output logic [15:0]                 overrun_count
`endif
);

  localparam logic [SAMPLE_W-1:0] P_AMP = SAMPLE_W'(AMPLITUDE);
  localparam logic [SAMPLE_W-1:0] P_ATK = SAMPLE_W'(ATTACK_STEP);
  localparam logic [SAMPLE_W-1:0] P_REL = SAMPLE_W'(RELEASE_STEP);

  function automatic logic [SAMPLE_W-1:0] amp_attack(input logic [SAMPLE_W-1:0] a);
    if ((a >= P_AMP) || ((P_AMP - a) <= P_ATK)) return P_AMP;
    return a + P_ATK;
  endfunction

  function automatic logic [SAMPLE_W-1:0] amp_release(input logic [SAMPLE_W-1:0] a);
    if (a <= P_REL) return '0;
    return a - P_REL;
  endfunction

  tone_state_e               r_state, w_state_nxt;
  logic [HALF_PERIOD_W-1:0]  r_half_period;
  logic [HALF_PERIOD_W-1:0]  r_phase;
  logic                      r_pol;
  logic [DURATION_W-1:0]     r_dur;
  logic [SAMPLE_W-1:0]       r_amp;
  logic signed [SAMPLE_W-1:0] r_sample;
  logic                      r_pending;

  logic                      w_tick;
  logic                      w_accept;
  logic                      w_write;
  logic                      w_end_note;
  logic [SAMPLE_W-1:0]       w_amp_att;
  logic [SAMPLE_W-1:0]       w_amp_rel;
  logic signed [SAMPLE_W-1:0] w_sample_nxt;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .o_tick  (w_tick)
  );

  assign note_ready = ((r_state == IDLE) || (r_state == RELEASE)) && !mute;
  assign w_accept   = note_valid && note_ready;
  assign busy       = (r_state != IDLE);
  assign w_write    = r_pending && audio_out_allowed;
  assign write_audio_out         = w_write;
  assign left_channel_audio_out  = r_sample;
  assign right_channel_audio_out = r_sample;

  assign w_amp_att  = amp_attack(r_amp);
  assign w_amp_rel  = amp_release(r_amp);
  assign w_end_note = (r_dur == '0) || mute;

  // The sample is formed from the amplitude before this tick's envelope step
  always_comb begin
    w_sample_nxt = '0;
    if ((r_half_period != '0) && (r_state != IDLE)) begin
      w_sample_nxt = r_pol ? -$signed(r_amp) : $signed(r_amp);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ATTACK;
    end else if (w_tick) begin
      case (r_state)
        ATTACK: begin
          if (w_end_note)              w_state_nxt = RELEASE;
          else if (w_amp_att == P_AMP) w_state_nxt = SUSTAIN;
        end
        SUSTAIN: begin
          if (w_end_note) w_state_nxt = RELEASE;
        end
        RELEASE: begin
          if (w_amp_rel == '0) w_state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Oscillator phase and envelope; accept keeps amp so a re-trigger is click-free
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_half_period <= '0;
      r_phase       <= '0;
      r_pol         <= 1'b0;
      r_dur         <= '0;
      r_amp         <= '0;
    end else if (w_accept) begin
      r_half_period <= note_half_period;
      r_phase       <= '0;
      r_pol         <= 1'b0;
      r_dur         <= note_duration;
    end else begin
      if (r_half_period == '0) begin
        r_phase <= '0;
      end else if (r_phase == (r_half_period - HALF_PERIOD_W'(1))) begin
        r_phase <= '0;
        r_pol   <= ~r_pol;
      end else begin
        r_phase <= r_phase + HALF_PERIOD_W'(1);
      end
      if (w_tick) begin
        case (r_state)
          ATTACK: begin
            r_amp <= w_amp_att;
            if (r_dur != '0) r_dur <= r_dur - DURATION_W'(1);
          end
          SUSTAIN: begin
            if (r_dur != '0) r_dur <= r_dur - DURATION_W'(1);
          end
          RELEASE: r_amp <= w_amp_rel;
          default: ;
        endcase
      end
    end
  end

  // A tick always wins: newest sample replaces any unwritten one
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sample  <= '0;
      r_pending <= 1'b0;
    end else if (w_tick) begin
      r_sample  <= w_sample_nxt;
      r_pending <= 1'b1;
    end else if (w_write) begin
      r_pending <= 1'b0;
    end
  end

`ifdef TONE_STREAMER_OVERRUN_CNT_EN
  logic        w_overrun;
  logic [15:0] r_overrun_cnt;

  assign w_overrun     = w_tick && r_pending && !audio_out_allowed;
  assign overrun_count = r_overrun_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun_cnt <= '0;
    end else if (w_overrun && (r_overrun_cnt != 16'hFFFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tone_sample_streamer.sv
// Directed bench for tone_sample_streamer with SAMPLE_DIV=8, AMPLITUDE=100, steps of 25.
module tb_tone_sample_streamer;

  logic               CLOCK_50 = 1'b0;
  logic               reset_n;
  logic               note_valid;
  logic               note_ready;
  logic [31:0]        note_half_period;
  logic [23:0]        note_duration;
  logic               mute;
  logic               audio_out_allowed;
  logic               write_audio_out;
  logic signed [31:0] left_channel_audio_out;
  logic signed [31:0] right_channel_audio_out;
  logic               busy;
`ifdef TONE_STREAMER_OVERRUN_CNT_EN
  logic [15:0]        overrun_count;
`endif

  int total = 0;
  int bad   = 0;

  tone_sample_streamer #(
    .SAMPLE_DIV   (8),
    .AMPLITUDE    (100),
    .ATTACK_STEP  (25),
    .RELEASE_STEP (25)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .reset_n                 (reset_n),
    .note_valid              (note_valid),
    .note_ready              (note_ready),
    .note_half_period        (note_half_period),
    .note_duration           (note_duration),
    .mute                    (mute),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .busy                    (busy)
`ifdef TONE_STREAMER_OVERRUN_CNT_EN
    ,
    .overrun_count           (overrun_count)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // act: 0 none, 1 offer note (half_period 16, duration 20), 2 raise mute
  typedef struct {
    int                 act;
    logic signed [31:0] exp_data;
    logic               exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for the next write strobe, sampled 1ns after a falling edge
  task automatic get_write(output logic found, output logic signed [31:0] data, output logic b);
    found = 1'b0;
    data  = '0;
    b     = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLOCK_50); #1;
      if (write_audio_out) begin
        found = 1'b1;
        data  = left_channel_audio_out;
        b     = busy;
        chk("right_eq_left", right_channel_audio_out, left_channel_audio_out);
        break;
      end
    end
    if (!found) chk("write_timeout", 0, 1);
  endtask

  task automatic offer_note(input logic [31:0] hp, input logic [23:0] dur);
    note_half_period = hp;
    note_duration    = dur;
    chk("ready_at_offer", note_ready, 1);
    note_valid = 1'b1;
    @(negedge CLOCK_50); #1;
    note_valid = 1'b0;
  endtask

  task automatic run_vecs(input string name);
    logic f;
    logic signed [31:0] d;
    logic b;
    foreach (vecs[i]) begin
      get_write(f, d, b);
      if (!f) return;
      chk({name, "_data"}, d, vecs[i].exp_data);
      chk({name, "_busy"}, b, vecs[i].exp_busy);
      if (vecs[i].act == 1) begin
        offer_note(32'd16, 24'd20);
      end else if (vecs[i].act == 2) begin
        mute = 1'b1;
        #1 chk("ready_muted", note_ready, 0);
      end
    end
  endtask

  function automatic vec_t mk(input int act, input int d, input logic b);
    vec_t v;
    v.act = act;
    v.exp_data = d;
    v.exp_busy = b;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    logic signed [31:0] d;
    logic b;
    int wcnt;

    reset_n = 1'b0;
    note_valid = 1'b0;
    note_half_period = '0;
    note_duration = '0;
    mute = 1'b0;
    audio_out_allowed = 1'b1;
    #12;
    chk("rst_write", write_audio_out, 0);
    chk("rst_left", left_channel_audio_out, 0);
    chk("rst_right", right_channel_audio_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", note_ready, 1);
    @(negedge CLOCK_50); #1;
    reset_n = 1'b1;

    // Basic note: attack, sustain, release with sign flipping every two samples
    get_write(f, d, b);
    offer_note(32'd16, 24'd10);
    vecs.delete();
    vecs.push_back(mk(0, 0, 1));    vecs.push_back(mk(0, 25, 1));
    vecs.push_back(mk(0, -50, 1));  vecs.push_back(mk(0, -75, 1));
    vecs.push_back(mk(0, 100, 1));  vecs.push_back(mk(0, 100, 1));
    vecs.push_back(mk(0, -100, 1)); vecs.push_back(mk(0, -100, 1));
    vecs.push_back(mk(0, 100, 1));  vecs.push_back(mk(0, 100, 1));
    vecs.push_back(mk(0, -100, 1)); vecs.push_back(mk(0, -100, 1));
    vecs.push_back(mk(0, 75, 1));   vecs.push_back(mk(0, 50, 1));
    vecs.push_back(mk(0, -25, 0));  vecs.push_back(mk(0, 0, 0));
    run_vecs("basic");

    // Silent note: envelope runs but every sample is zero
    get_write(f, d, b);
    offer_note(32'd0, 24'd4);
    vecs.delete();
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 1));
    vecs.push_back(mk(0, 0, 0));
    run_vecs("silent");

    // Re-trigger at amp 50 in release, then mute during sustain
    get_write(f, d, b);
    offer_note(32'd16, 24'd4);
    vecs.delete();
    vecs.push_back(mk(0, 0, 1));    vecs.push_back(mk(0, 25, 1));
    vecs.push_back(mk(0, -50, 1));  vecs.push_back(mk(0, -75, 1));
    vecs.push_back(mk(0, 100, 1));  vecs.push_back(mk(0, 100, 1));
    vecs.push_back(mk(1, -75, 1));
    vecs.push_back(mk(0, 50, 1));   vecs.push_back(mk(2, 75, 1));
    vecs.push_back(mk(0, -100, 1)); vecs.push_back(mk(0, -100, 1));
    vecs.push_back(mk(0, 75, 1));   vecs.push_back(mk(0, 50, 1));
    vecs.push_back(mk(0, -25, 0));
    run_vecs("retrig");
    chk("mute_idle_ready", note_ready, 0);
    note_half_period = 32'd16;
    note_duration = 24'd5;
    note_valid = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    #1 chk("mute_blocks_accept", busy, 0);
    note_valid = 1'b0;
    mute = 1'b0;
    #1 chk("unmute_ready", note_ready, 1);

    // FIFO full for three ticks: one write of the third tick's sample
    get_write(f, d, b);
    offer_note(32'd16, 24'd100);
    audio_out_allowed = 1'b0;
    wcnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge CLOCK_50); #1;
      if (write_audio_out) wcnt++;
    end
    chk("blocked_writes", wcnt, 0);
    audio_out_allowed = 1'b1;
    #1;
    chk("late_write_strobe", write_audio_out, 1);
    chk("late_write_data", left_channel_audio_out, -50);
    wcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (write_audio_out) wcnt++;
      @(negedge CLOCK_50); #1;
    end
    chk("late_write_count", wcnt, 1);
`ifdef TONE_STREAMER_OVERRUN_CNT_EN
    chk("overrun_count", overrun_count, 2);
`endif

    // Reset in sustain aborts the note at once
    repeat (30) @(negedge CLOCK_50);
    #1 chk("sustain_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_write", write_audio_out, 0);
    chk("midrst_left", left_channel_audio_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", note_ready, 1);
`ifdef TONE_STREAMER_OVERRUN_CNT_EN
    chk("midrst_overrun", overrun_count, 0);
`endif
    wcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLOCK_50); #1;
      if (write_audio_out) wcnt++;
    end
    chk("held_rst_writes", wcnt, 0);
    reset_n = 1'b1;
    wcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK_50); #1;
      if (busy) wcnt++;
      if (write_audio_out && left_channel_audio_out != 0) wcnt++;
    end
    chk("post_rst_quiet", wcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sample_streamer.md
Name: tone_sample_streamer

Overview:
- Downstream of the melody sequencer and upstream of Audio_Controller.
- Accepts one note at a time (half-period in CLOCK_50 cycles, duration in sample ticks) through a valid/ready handshake.
- Synthesises an enveloped square wave and delivers one signed 32-bit sample per sample tick to the audio-out FIFO using the audio_out_allowed / write_audio_out handshake.
- Replaces free-running, unpaced sample writes with paced, click-free notes.

Parameters:
- SAMPLE_DIV, 1042: CLOCK_50 cycles per sample tick (about 48 kHz).
- AMPLITUDE, 100000000: peak magnitude of the output sample.
- ATTACK_STEP, 2000000: amplitude increment per tick in ATTACK.
- RELEASE_STEP, 2000000: amplitude decrement per tick in RELEASE.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- note_valid  in  1  note offered.
- note_ready  out  1  note can be accepted.
- note_half_period  in  32  CLOCK_50 cycles per half wave; 0 means silence.
- note_duration  in  24  sample ticks before release begins.
- mute  in  1  force release, block new notes.
- audio_out_allowed  in  1  FIFO has space.
- write_audio_out  out  1  sample write strobe.
- left_channel_audio_out  out  32  signed sample.
- right_channel_audio_out  out  32  same as left.
- busy  out  1  state not IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, amp 0, polarity 0, pending 0, tick divider 0, sample register 0.
  - Reset outputs: write_audio_out 0, audio outputs 0, busy 0, note_ready 1.
  - Reset mid-note aborts with no further writes.
- States:
  - IDLE to ATTACK on accept.
  - ATTACK to SUSTAIN when amp reaches AMPLITUDE.
  - ATTACK or SUSTAIN to RELEASE when the duration counter is 0 at a tick, or mute is high at a tick.
  - RELEASE to IDLE when amp reaches 0.
  - RELEASE to ATTACK on accept.
- note_ready = (IDLE or RELEASE) and not mute.
- Accept = note_valid & note_ready.
- On accept (edge t):
  - Latch half_period, load the duration counter, clear the phase counter and polarity.
  - amp keeps its current value, so a re-trigger from RELEASE has no step discontinuity.
  - ATTACK is in effect from t+1.
- Phase counter:
  - Increments every CLOCK_50 cycle.
  - At half_period-1 it wraps to 0 and polarity toggles.
  - Held at 0 when half_period is 0.
- Tick: the divider counts 0..SAMPLE_DIV-1; a tick fires on the wrap cycle. The divider is free-running, unaffected by notes.
- On a tick:
  - Sample = 0 if half_period is 0 or state is IDLE; otherwise polarity ? -amp : +amp (two's complement, 32-bit). The pre-update amp is used.
  - Then the envelope updates:
    - ATTACK: amp = min(amp+ATTACK_STEP, AMPLITUDE).
    - RELEASE: amp = max(amp-RELEASE_STEP, 0), with no unsigned underflow.
    - ATTACK/SUSTAIN: the duration counter decrements, saturating at 0.
  - A duration of 0 enters RELEASE at the first tick.
- Handshake:
  - The tick loads the sample register and sets pending.
  - write_audio_out = pending & audio_out_allowed (combinational); pending clears on that edge.
  - Data is stable whenever pending is 1.
- Boundaries:
  - Tick while pending and not writing: the sample is replaced (newest wins) and an overrun is recorded.
  - Tick in the same cycle as a write: the old sample is written, the new one is loaded, pending stays 1, no overrun.
  - audio_out_allowed held low: no writes; the envelope still advances.
- The sample register updates only on ticks; outputs hold between ticks.

Optional Feature:
- Macro: TONE_STREAMER_OVERRUN_CNT_EN.
- Defined: adds output overrun_count[15:0].
  - Increments on each overrun as defined above and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; overruns are silent.

Decomposition:
- Package tone_stream_pkg holds:
  - the state enum (IDLE, ATTACK, SUSTAIN, RELEASE);
  - SAMPLE_W=32, HALF_PERIOD_W=32, DURATION_W=24;
  - the default AMPLITUDE.
- Sub-module sample_tick_gen (parameter SAMPLE_DIV): free-running divider emitting a one-cycle tick pulse.

Test Plan:
- Reset → write_audio_out=0, audio outputs 0, note_ready=1, busy=0; pulse reset_n low mid-SUSTAIN → same values immediately and no writes afterwards.
- SAMPLE_DIV=8, AMPLITUDE=100, steps=25, half_period=16, duration=10, audio_out_allowed=1 → written magnitudes 0,25,50,75,100,100…; sign flips every 2 samples; release 100,75,50,25, then IDLE and busy=0.
- Re-trigger during RELEASE at amp=50 with a new note → accepted; the next sample magnitude is 50, then 75.
- audio_out_allowed=0 for 3 ticks then 1 → exactly one write, carrying the third tick's sample; overrun_count=2 (macro on).
- half_period=0, duration=4 → all written samples are 0 while busy is 1; returns to IDLE after the envelope completes.
- mute=1 during SUSTAIN → RELEASE at the next tick and note_ready=0 even in IDLE; mute=0 → note_ready=1.
